display_scheduler: RTL and testbench

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

---
 rtl/lock_disp_pkg.sv | 38 +++
 rtl/display_scheduler_if.sv | 37 +++
 rtl/disp_timer.sv | 48 ++++
 rtl/display_scheduler.sv | 168 ++++++++++++++++
 tb/tb_display_scheduler.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/lock_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lock_disp_pkg
// Description : Shared display types for the lock keypad display path.
//               Holds the six-digit BCD packet type, the display-owner
//               enumeration and the special digit codes understood by the
//               seven-segment controller.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package lock_disp_pkg;

  // Non-numeric glyph codes understood by the 7-segment controller.
  localparam logic [3:0] DIG_DASH  = 4'hA;
  localparam logic [3:0] DIG_BLANK = 4'hB;

  // Six BCD digits; BCD5 is the most significant nibble of the packed word.
  typedef struct packed {
    logic [3:0] BCD5;
    logic [3:0] BCD4;
    logic [3:0] BCD3;
    logic [3:0] BCD2;
    logic [3:0] BCD1;
    logic [3:0] BCD0;
  } bcdPac_t;

  // Which source currently owns the display (also the scheduler FSM state).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    MSG   = 2'd2,
    ALARM = 2'd3
  } disp_src_t;

  localparam bcdPac_t BCD_BLANK = '{default: DIG_BLANK};

endpackage
`default_nettype wire

// File: rtl/display_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : display_scheduler_if
// Description : Request/response bundle between the display sources and the
//               display scheduler.
// Ports       : master - drives entry/msg/alarm requests and digits,
//                        observes msg_ack, msg_done, bcd_packet, enable, owner
//               slave  - the scheduler side (directions reversed)
// Revision    : 1.0 - initial release
// ============================================================================
interface display_scheduler_if;
  import lock_disp_pkg::*;

  logic      entry_valid;
  bcdPac_t   entry_pkt;
  logic      msg_req;
  bcdPac_t   msg_pkt;
  logic      alarm_req;
  bcdPac_t   alarm_pkt;
  logic      msg_ack;
  logic      msg_done;
  bcdPac_t   bcd_packet;
  logic      enable;
  disp_src_t owner;

  modport master (
    output entry_valid, entry_pkt, msg_req, msg_pkt, alarm_req, alarm_pkt,
    input  msg_ack, msg_done, bcd_packet, enable, owner
  );

  modport slave (
    input  entry_valid, entry_pkt, msg_req, msg_pkt, alarm_req, alarm_pkt,
    output msg_ack, msg_done, bcd_packet, enable, owner
  );

endinterface
`default_nettype wire

// File: rtl/disp_timer.sv
`default_nettype none
// ============================================================================
// Module      : disp_timer
// Description : Loadable down-counter with freeze. The count represents the
//               number of ticks still to run; zero_o flags the tick that
//               brings the count to zero, so a load of N yields exactly N
//               ticks before the flag's tick completes.
// Ports       : clk, rst     - clock, asynchronous active-high reset
//               load_i       - load value_i (overrides counting)
//               value_i      - reload value
//               freeze_i     - hold the current count
//               zero_o       - count reaches zero on this tick
// Revision    : 1.0 - initial release
// ============================================================================
module disp_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  input  logic             freeze_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (!freeze_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = !freeze_i && (count_q == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : display_scheduler
// Description : Arbitrates the six-digit display between keypad entry, timed
//               status messages and the alarm/lockout display
//               (ALARM > MSG > ENTRY > IDLE). All outputs are registered;
//               enable strobes once for every change of bcd_packet and once
//               after reset release.
// Ports       : clk, rst   - clock, asynchronous active-high reset
//               bus        - display_scheduler_if.slave (requests, digits,
//                            msg_ack, msg_done, bcd_packet, enable, owner)
// Parameters  : HOLD_CYCLES - message hold time in clk cycles (>= 2)
//               BLINK_HALF  - alarm blink half-period in clk cycles (>= 1)
// Macros      : DISPLAY_BLINK_EN - blink the alarm display; when undefined
//               the alarm digits are shown steadily and BLINK_HALF is unused.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scheduler
  import lock_disp_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int BLINK_HALF  = 25_000_000
) (
  input  logic               clk,
  input  logic               rst,
  display_scheduler_if.slave bus
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  disp_src_t state_q, state_d;
  bcdPac_t   bcd_q, bcd_d;
  bcdPac_t   msg_q, msg_d;
  bcdPac_t   w_alarm_view;
  logic      enable_q, enable_d;
  logic      ack_q, done_q;
  logic      frozen_q, frozen_d;
  logic      init_q;
  logic      w_accept;
  logic      w_hold_zero;

  // A new message is taken when no message is live or frozen, or in the very
  // cycle the current one expires; an active alarm always defers it.
  assign w_accept = bus.msg_req && !bus.alarm_req &&
                    (((state_q != MSG) && !frozen_q) || w_hold_zero);

  // Counts only while the message is on screen; an alarm leaves it frozen.
  disp_timer #(.WIDTH(HOLD_W)) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (w_accept),
    .value_i  (HOLD_W'(HOLD_CYCLES)),
    .freeze_i (state_q != MSG),
    .zero_o   (w_hold_zero)
  );

`ifdef DISPLAY_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_HALF + 1);

  logic blink_on_q, blink_on_d;
  logic w_blink_zero, w_alarm_entry, w_blink_reload;

  assign w_alarm_entry  = (state_d == ALARM) && (state_q != ALARM);
  assign w_blink_reload = w_alarm_entry || ((state_q == ALARM) && w_blink_zero);

  disp_timer #(.WIDTH(BLINK_W)) u_blink_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (w_blink_reload),
    .value_i  (BLINK_W'(BLINK_HALF)),
    .freeze_i (state_q != ALARM),
    .zero_o   (w_blink_zero)
  );

  // Every ALARM entry restarts the phase with the digits visible.
  always_comb begin
    blink_on_d = blink_on_q;
    if (w_alarm_entry) begin
      blink_on_d = 1'b1;
    end else if ((state_q == ALARM) && w_blink_zero) begin
      blink_on_d = !blink_on_q;
    end
    w_alarm_view = blink_on_d ? bus.alarm_pkt : BCD_BLANK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_on_q <= 1'b0;
    end else begin
      blink_on_q <= blink_on_d;
    end
  end
`else
  assign w_alarm_view = bus.alarm_pkt;
`endif

  always_comb begin
    state_d  = IDLE;
    frozen_d = frozen_q;
    msg_d    = msg_q;
    bcd_d    = BCD_BLANK;

    if (bus.alarm_req) begin
      state_d = ALARM;
    end else if (w_accept) begin
      state_d = MSG;
    end else if ((state_q == MSG) && !w_hold_zero) begin
      state_d = MSG;
    end else if ((state_q == ALARM) && frozen_q) begin
      state_d = MSG;
    end else if (bus.entry_valid) begin
      state_d = ENTRY;
    end

    // A message that expires in the cycle the alarm arrives is finished, not
    // frozen.
    if ((state_q == MSG) && bus.alarm_req && !w_hold_zero) begin
      frozen_d = 1'b1;
    end else if ((state_q == ALARM) && !bus.alarm_req) begin
      frozen_d = 1'b0;
    end

    if (w_accept) begin
      msg_d = bus.msg_pkt;
    end

    case (state_d)
      IDLE:    bcd_d = BCD_BLANK;
      ENTRY:   bcd_d = bus.entry_pkt;
      MSG:     bcd_d = msg_d;
      ALARM:   bcd_d = w_alarm_view;
      default: bcd_d = BCD_BLANK;
    endcase

    // init_q forces one strobe after reset so the controller repaints blanks.
    enable_d = init_q || (bcd_d != bcd_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bcd_q    <= BCD_BLANK;
      msg_q    <= BCD_BLANK;
      enable_q <= 1'b0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      frozen_q <= 1'b0;
      init_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      msg_q    <= msg_d;
      enable_q <= enable_d;
      ack_q    <= w_accept;
      done_q   <= w_hold_zero;
      frozen_q <= frozen_d;
      init_q   <= 1'b0;
    end
  end

  assign bus.owner      = state_q;
  assign bus.bcd_packet = bcd_q;
  assign bus.enable     = enable_q;
  assign bus.msg_ack    = ack_q;
  assign bus.msg_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scheduler
// Description : Self-checking bench for display_scheduler with HOLD_CYCLES=8
//               and BLINK_HALF=4. Expected outputs are queued as stimulus is
//               applied and popped after each clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scheduler;
  import lock_disp_pkg::*;

  localparam int HOLD  = 8;
  localparam int BLINK = 4;

  localparam logic [23:0] BL = 24'hBBBBBB;
  localparam logic [23:0] E1 = 24'h123456;
  localparam logic [23:0] E2 = 24'h123457;
  localparam logic [23:0] MA = 24'hAAAAAA;
  localparam logic [23:0] MB = 24'h654321;
  localparam logic [23:0] AL = 24'h999000;

  typedef struct packed {
    logic [23:0] bcd;
    logic        en;
    disp_src_t   own;
    logic        ack;
    logic        done;
  } exp_t;

  typedef struct packed {
    logic        ev;
    logic [23:0] ep;
    logic        mr;
    logic [23:0] mp;
    logic        ar;
  } stim_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  display_scheduler_if bus();

  display_scheduler #(
    .HOLD_CYCLES (HOLD),
    .BLINK_HALF  (BLINK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vt[14];

  function automatic exp_t ex(input logic [23:0] b, input logic en,
                              input disp_src_t o, input logic a, input logic d);
    exp_t r;
    r.bcd = b; r.en = en; r.own = o; r.ack = a; r.done = d;
    return r;
  endfunction

  function automatic stim_t st(input logic ev, input logic [23:0] ep,
                               input logic mr, input logic [23:0] mp,
                               input logic ar);
    stim_t r;
    r.ev = ev; r.ep = ep; r.mr = mr; r.mp = mp; r.ar = ar;
    return r;
  endfunction

  // Alarm display k cycles after ALARM entry.
  function automatic logic [23:0] alm_bcd(input int k);
`ifdef DISPLAY_BLINK_EN
    return (((k / BLINK) % 2) == 0) ? AL : BL;
`else
    return AL;
`endif
  endfunction

  function automatic logic alm_en(input int k);
`ifdef DISPLAY_BLINK_EN
    return (k % BLINK) == 0;
`else
    return k == 0;
`endif
  endfunction

  task automatic apply(input stim_t s);
    bus.entry_valid = s.ev;
    bus.entry_pkt   = bcdPac_t'(s.ep);
    bus.msg_req     = s.mr;
    bus.msg_pkt     = bcdPac_t'(s.mp);
    bus.alarm_req   = s.ar;
    bus.alarm_pkt   = bcdPac_t'(AL);
  endtask

  task automatic check(input string tag);
    exp_t e;
    exp_t g;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, nothing to compare", tag);
      return;
    end
    e = sb_q.pop_front();
    g.bcd  = bus.bcd_packet;
    g.en   = bus.enable;
    g.own  = bus.owner;
    g.ack  = bus.msg_ack;
    g.done = bus.msg_done;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got bcd=%h en=%b owner=%0d ack=%b done=%b, expected bcd=%h en=%b owner=%0d ack=%b done=%b",
               tag, g.bcd, g.en, g.own, g.ack, g.done,
               e.bcd, e.en, e.own, e.ack, e.done);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic cyc(input stim_t s, input exp_t e, input string tag);
    apply(s);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t idle_s;
    idle_s = st(1'b0, E1, 1'b0, MA, 1'b0);

    // Reset state and the post-release enable pulse.
    rst = 1'b1;
    apply(idle_s);
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back(ex(BL, 1'b0, IDLE, 1'b0, 1'b0));
    check("reset_state");
    rst = 1'b0;
    cyc(idle_s, ex(BL, 1'b1, IDLE, 1'b0, 1'b0), "rst_release_en");
    cyc(idle_s, ex(BL, 1'b0, IDLE, 1'b0, 1'b0), "idle_quiet");

    // Entry display, live digit update, message over entry and return.
    vt[0] = '{s: st(1'b1, E1, 1'b0, MA, 1'b0), e: ex(E1, 1'b1, ENTRY, 1'b0, 1'b0)};
    vt[1] = '{s: st(1'b1, E1, 1'b0, MA, 1'b0), e: ex(E1, 1'b0, ENTRY, 1'b0, 1'b0)};
    vt[2] = '{s: st(1'b1, E2, 1'b0, MA, 1'b0), e: ex(E2, 1'b1, ENTRY, 1'b0, 1'b0)};
    vt[3] = '{s: st(1'b1, E1, 1'b1, MA, 1'b0), e: ex(MA, 1'b1, MSG,   1'b1, 1'b0)};
    for (int i = 4; i <= 10; i++) begin
      vt[i] = '{s: st(1'b1, E1, 1'b0, MA, 1'b0), e: ex(MA, 1'b0, MSG, 1'b0, 1'b0)};
    end
    vt[11] = '{s: st(1'b1, E1, 1'b0, MA, 1'b0), e: ex(E1, 1'b1, ENTRY, 1'b0, 1'b1)};
    vt[12] = '{s: st(1'b0, E1, 1'b0, MA, 1'b0), e: ex(BL, 1'b1, IDLE,  1'b0, 1'b0)};
    vt[13] = '{s: st(1'b0, E1, 1'b0, MA, 1'b0), e: ex(BL, 1'b0, IDLE,  1'b0, 1'b0)};
    for (int i = 0; i < 14; i++) begin
      cyc(vt[i].s, vt[i].e, $sformatf("tbl%0d", i));
    end

    // Alarm 3 cycles into a message, held 10 cycles; 5 cycles remain after.
    cyc(st(1'b0, E1, 1'b1, MA, 1'b0), ex(MA, 1'b1, MSG, 1'b1, 1'b0), "frz_ack");
    for (int i = 0; i < 2; i++) begin
      cyc(idle_s, ex(MA, 1'b0, MSG, 1'b0, 1'b0), $sformatf("frz_msg%0d", i));
    end
    for (int k = 0; k < 10; k++) begin
      cyc(st(1'b0, E1, 1'b0, MA, 1'b1), ex(alm_bcd(k), alm_en(k), ALARM, 1'b0, 1'b0),
          $sformatf("frz_alarm%0d", k));
    end
    cyc(idle_s, ex(MA, 1'b1, MSG, 1'b0, 1'b0), "frz_resume");
    for (int i = 0; i < 4; i++) begin
      cyc(idle_s, ex(MA, 1'b0, MSG, 1'b0, 1'b0), $sformatf("frz_rest%0d", i));
    end
    cyc(idle_s, ex(BL, 1'b1, IDLE, 1'b0, 1'b1), "frz_done");

    // Message request during alarm is deferred until the alarm drops.
    cyc(st(1'b0, E1, 1'b0, MA, 1'b1), ex(alm_bcd(0), 1'b1, ALARM, 1'b0, 1'b0), "dfr_alarm");
    cyc(st(1'b0, E1, 1'b1, MB, 1'b1), ex(alm_bcd(1), alm_en(1), ALARM, 1'b0, 1'b0), "dfr_noack");
    cyc(st(1'b0, E1, 1'b1, MB, 1'b0), ex(MB, 1'b1, MSG, 1'b1, 1'b0), "dfr_ack");
    for (int i = 0; i < HOLD - 1; i++) begin
      cyc(st(1'b0, E1, 1'b0, MB, 1'b0), ex(MB, 1'b0, MSG, 1'b0, 1'b0), $sformatf("dfr_hold%0d", i));
    end

    // Next request lands in the expiry cycle: done and ack together.
    cyc(st(1'b0, E1, 1'b1, MA, 1'b0), ex(MA, 1'b1, MSG, 1'b1, 1'b1), "exp_swap");
    for (int i = 0; i < HOLD - 1; i++) begin
      cyc(idle_s, ex(MA, 1'b0, MSG, 1'b0, 1'b0), $sformatf("exp_hold%0d", i));
    end
    cyc(idle_s, ex(BL, 1'b1, IDLE, 1'b0, 1'b1), "exp_done");

    // Alarm held 16 cycles (blinks when DISPLAY_BLINK_EN is defined).
    for (int k = 0; k < 16; k++) begin
      cyc(st(1'b0, E1, 1'b0, MA, 1'b1), ex(alm_bcd(k), alm_en(k), ALARM, 1'b0, 1'b0),
          $sformatf("blk%0d", k));
    end
    cyc(idle_s, ex(BL, (alm_bcd(15) != BL), IDLE, 1'b0, 1'b0), "blk_release");

    // Reset in the middle of a message.
    cyc(st(1'b0, E1, 1'b1, MA, 1'b0), ex(MA, 1'b1, MSG, 1'b1, 1'b0), "rm_ack");
    for (int i = 0; i < 2; i++) begin
      cyc(idle_s, ex(MA, 1'b0, MSG, 1'b0, 1'b0), $sformatf("rm_msg%0d", i));
    end
    rst = 1'b1;
    #1;
    sb_q.push_back(ex(BL, 1'b0, IDLE, 1'b0, 1'b0));
    check("rm_async");
    for (int i = 0; i < 2; i++) begin
      cyc(idle_s, ex(BL, 1'b0, IDLE, 1'b0, 1'b0), $sformatf("rm_hold%0d", i));
    end
    rst = 1'b0;
    cyc(idle_s, ex(BL, 1'b1, IDLE, 1'b0, 1'b0), "rm_release_en");
    for (int i = 0; i < 6; i++) begin
      cyc(idle_s, ex(BL, 1'b0, IDLE, 1'b0, 1'b0), $sformatf("rm_no_done%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
